prog_loader: RTL and testbench

- Hardware program loader for the rv16r core. It is the write side of instruction memory, replacing the simulation-only hex preload.
- Receives a framed byte stream (header, instruction words, checksum) and writes each 16-bit word into the instruction RAM write port.
- Holds the core in reset until a complete, checksum-valid image has been written.
- Sits between the byte source (UART receiver or bench driver) and the Instructions RAM, and drives the core's rst.

---
 rtl/prog_loader_if.sv | 23 ++
 rtl/prog_loader.sv | 157 +++++++++++++++
 tb/tb_prog_loader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-RAM write port of the rv16r program loader.
interface prog_loader_if #(
  parameter int ADDR_W = 10
) ();
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;

  // Byte source plus RAM side: drives the stream, observes ready and the write port
  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // Loader side: consumes the stream and drives the RAM write port
  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader for rv16r: parses a framed byte stream (count, words, checksum),
// writes each 16-bit word to instruction RAM and releases the core from reset
// only after a complete image with a valid checksum. MAX_WORDS must not exceed
// 2**ADDR_W so the write address can never wrap.
module prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic            clk,
  input  logic            rst,
  prog_loader_if.slave    bus,
  input  logic            restart,
  output logic            cpu_rst,
  output logic            load_done,
  output logic            load_err,
  output logic [ADDR_W:0] words_loaded
);

  typedef enum logic [2:0] {
    HDR_HI, HDR_LO, DATA_HI, DATA_LO, CSUM, DONE, ERR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        sum_q, sum_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              in_ready;
  logic              accept;
  logic [7:0]        sum_next;
  logic [15:0]       hdr_count;

  // Ready is a pure decode of the registered state: every state but DONE/ERR takes bytes
  always_comb begin
    in_ready = (state_q != DONE) && (state_q != ERR);
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_rst       = cpu_rst_q;
  assign load_done     = done_q;
  assign load_err      = err_q;
  assign words_loaded  = words_q;

  // Next-state logic: restart wins over a byte accept (the byte is dropped),
  // while a write already registered for this cycle still reaches the RAM
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    hi_d        = hi_q;
    sum_d       = sum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    words_d     = words_q;
    cpu_rst_d   = cpu_rst_q;
    done_d      = done_q;
    err_d       = err_q;

    accept    = bus.in_valid & in_ready;
    sum_next  = sum_q + bus.in_data;
    hdr_count = {count_q[15:8], bus.in_data};

    if (restart) begin
      state_d   = HDR_HI;
      count_d   = '0;
      sum_d     = '0;
      words_d   = '0;
      cpu_rst_d = 1'b1;
      done_d    = 1'b0;
      err_d     = 1'b0;
    end else if (accept) begin
      sum_d = sum_next;
      case (state_q)
        HDR_HI: begin
          count_d[15:8] = bus.in_data;
          state_d       = HDR_LO;
        end
        HDR_LO: begin
          count_d[7:0] = bus.in_data;
          if ((hdr_count == 16'd0) || (32'(hdr_count) > 32'(MAX_WORDS))) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d = DATA_HI;
          end
        end
        DATA_HI: begin
          hi_d    = bus.in_data;
          state_d = DATA_LO;
        end
        DATA_LO: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = words_q[ADDR_W-1:0];
          mem_wdata_d = {hi_q, bus.in_data};
          words_d     = words_q + 1'b1;
          if ((32'(words_q) + 32'd1) == 32'(count_q)) begin
            state_d = CSUM;
          end else begin
            state_d = DATA_HI;
          end
        end
        CSUM: begin
          if (sum_next == 8'h00) begin
            state_d   = DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // All loader state and outputs are registered here; rst aborts a load at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HDR_HI;
      count_q     <= '0;
      hi_q        <= '0;
      sum_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      words_q     <= '0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      hi_q        <= hi_d;
      sum_q       <= sum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      words_q     <= words_d;
      cpu_rst_q   <= cpu_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: nominal load, checksum and length errors,
// stalled stream, asynchronous abort and restart/reload.
module tb_prog_loader;
  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;

  typedef logic [7:0] byte_q_t[$];

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            restart = 1'b0;
  logic            cpu_rst;
  logic            load_done;
  logic            load_err;
  logic [ADDR_W:0] words_loaded;

  prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .restart      (restart),
    .cpu_rst      (cpu_rst),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [25:0] wrLog[$];
  logic prevWe = 1'b0;
  int backToBack = 0;

  // Record every RAM write and flag any two-cycle write strobe
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) wrLog.push_back({bus.mem_addr, bus.mem_wdata});
    if (prevWe && (bus.mem_we === 1'b1)) backToBack++;
    prevWe = (bus.mem_we === 1'b1);
  end

  // Bound the whole run in case the design stops accepting bytes
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present one byte after an idle gap and hold it until the loader takes it
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    bit taken;
    taken = 1'b0;
    bus.in_valid = 1'b0;
    repeat (gap) begin
      bus.in_data = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !taken; i++) begin
      taken = (bus.in_ready === 1'b1);
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (!taken) checkOutput("accept timeout", 32'd0, 32'd1);
  endtask

  task automatic sendFrame(input byte_q_t frame, input int maxGap);
    foreach (frame[i]) applyStimulus(frame[i], (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
  endtask

  task automatic checkWrite(input int idx, input logic [ADDR_W-1:0] a, input logic [15:0] d);
    if (idx < wrLog.size()) begin
      checkOutput($sformatf("wr%0d addr", idx), 32'(wrLog[idx][25:16]), 32'(a));
      checkOutput($sformatf("wr%0d data", idx), 32'(wrLog[idx][15:0]), 32'(d));
    end else begin
      checkOutput($sformatf("wr%0d missing", idx), 32'(wrLog.size()), 32'(idx + 1));
    end
  endtask

  task automatic checkFinal(input string tag, input logic done, input logic err, input int words);
    checkOutput({tag, " load_done"}, 32'(load_done), 32'(done));
    checkOutput({tag, " load_err"}, 32'(load_err), 32'(err));
    checkOutput({tag, " cpu_rst"}, 32'(cpu_rst), 32'(!done));
    checkOutput({tag, " in_ready"}, 32'(bus.in_ready), 32'd0);
    checkOutput({tag, " words_loaded"}, 32'(words_loaded), 32'(words));
  endtask

  task automatic pulseRestart(input string tag);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    checkOutput({tag, " cpu_rst"}, 32'(cpu_rst), 32'd1);
    checkOutput({tag, " load_done"}, 32'(load_done), 32'd0);
    checkOutput({tag, " load_err"}, 32'(load_err), 32'd0);
    checkOutput({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    checkOutput({tag, " words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    byte_q_t f;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    // Reset values while rst is held
    #12;
    checkOutput("rst cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("rst load_done", 32'(load_done), 32'd0);
    checkOutput("rst load_err", 32'(load_err), 32'd0);
    checkOutput("rst words", 32'(words_loaded), 32'd0);
    checkOutput("rst mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("rst mem_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("rst mem_wdata", 32'(bus.mem_wdata), 32'd0);
    checkOutput("rst in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Nominal two-word load with byte-level timing checks
    wrLog.delete();
    applyStimulus(8'h00, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h12, 0);
    checkOutput("nom no early we", 32'(bus.mem_we), 32'd0);
    applyStimulus(8'h34, 0);
    checkOutput("nom lat mem_we", 32'(bus.mem_we), 32'd1);
    checkOutput("nom lat addr", 32'(bus.mem_addr), 32'h000);
    checkOutput("nom lat wdata", 32'(bus.mem_wdata), 32'h1234);
    checkOutput("nom words1", 32'(words_loaded), 32'd1);
    applyStimulus(8'hAB, 0);
    checkOutput("nom we one cycle", 32'(bus.mem_we), 32'd0);
    applyStimulus(8'hCD, 0);
    checkOutput("nom pre csum cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("nom pre csum done", 32'(load_done), 32'd0);
    applyStimulus(8'h40, 0);
    checkFinal("nom", 1'b1, 1'b0, 2);
    checkOutput("nom writes", 32'(wrLog.size()), 32'd2);
    checkWrite(0, 10'd0, 16'h1234);
    checkWrite(1, 10'd1, 16'hABCD);
    repeat (3) @(negedge clk);
    checkOutput("nom done sticky", 32'(load_done), 32'd1);

    // Restart from DONE, then the same frame with a bad checksum
    pulseRestart("rs1");
    wrLog.delete();
    f = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    sendFrame(f, 0);
    checkFinal("badsum", 1'b0, 1'b1, 2);
    checkOutput("badsum writes", 32'(wrLog.size()), 32'd2);
    checkWrite(0, 10'd0, 16'h1234);
    checkWrite(1, 10'd1, 16'hABCD);

    // Length errors: zero words and one beyond MAX_WORDS
    pulseRestart("rs2");
    wrLog.delete();
    f = {8'h00, 8'h00};
    sendFrame(f, 0);
    checkFinal("len0", 1'b0, 1'b1, 0);
    checkOutput("len0 writes", 32'(wrLog.size()), 32'd0);
    pulseRestart("rs3");
    f = {8'h04, 8'h01};
    sendFrame(f, 0);
    checkFinal("len1025", 1'b0, 1'b1, 0);
    checkOutput("len1025 writes", 32'(wrLog.size()), 32'd0);

    // Nominal frame with random idle gaps between bytes
    pulseRestart("rs4");
    wrLog.delete();
    f = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    sendFrame(f, 4);
    checkFinal("stall", 1'b1, 1'b0, 2);
    checkOutput("stall writes", 32'(wrLog.size()), 32'd2);
    checkWrite(0, 10'd0, 16'h1234);
    checkWrite(1, 10'd1, 16'hABCD);

    // Asynchronous abort after the third data byte of a four-word image
    pulseRestart("rs5");
    f = {8'h00, 8'h04, 8'h11, 8'h22, 8'h33};
    sendFrame(f, 0);
    checkOutput("abort pre wdata", 32'(bus.mem_wdata), 32'h1122);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("abort words", 32'(words_loaded), 32'd0);
    checkOutput("abort mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("abort mem_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("abort mem_wdata", 32'(bus.mem_wdata), 32'd0);
    checkOutput("abort in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wrLog.delete();
    f = {8'h00, 8'h01, 8'h00, 8'h13, 8'hEC};
    sendFrame(f, 0);
    checkFinal("reload", 1'b1, 1'b0, 1);
    checkOutput("reload writes", 32'(wrLog.size()), 32'd1);
    checkWrite(0, 10'd0, 16'h0013);

    // Restart from DONE and load a second image
    pulseRestart("rs6");
    wrLog.delete();
    f = {8'h00, 8'h01, 8'hBE, 8'hEF, 8'h52};
    sendFrame(f, 2);
    checkFinal("second", 1'b1, 1'b0, 1);
    checkOutput("second writes", 32'(wrLog.size()), 32'd1);
    checkWrite(0, 10'd0, 16'hBEEF);

    checkOutput("no back-to-back we", 32'(backToBack), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
